dmem_port_arbiter: RTL and testbench

- Shares the single-port data RAM between two requesters: the CPU MEM stage and the UART loader/dumper.
- Issues one RAM access per cycle and returns read data one cycle later, tagged to its owner.
- Produces `cpu_stall` so the pipeline holds its MEM-stage access until it is granted.
- Supports a lock mode: the UART gains exclusive RAM access for bulk load/dump while the CPU is held off.

---
 rtl/dmem_port_arbiter_pkg.sv | 24 ++
 rtl/dmem_port_arbiter_starve_counter.sv | 39 +++
 rtl/dmem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and default widths for the data-RAM port arbiter.
// The optional round-robin build is selected with DMEM_ARB_RR_EN.
package dmem_port_arbiter_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

  // Wide enough for the largest supported starvation limit (15).
  localparam int STARVE_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_LOCK_PEND = 2'd1,
    ST_LOCKED    = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_UART = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_port_arbiter_starve_counter.sv
// Saturating count of consecutive CPU wins while the UART is waiting.
// limit_hit tells the arbiter to hand the next conflict to the UART.
module arb_starve_counter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  localparam logic [STARVE_CNT_W-1:0] MAX_C = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; the count parks at the limit until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_hit = (cnt_q == MAX_C);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data RAM between the CPU MEM stage and the UART loader.
// Build option DMEM_ARB_RR_EN replaces CPU priority + starvation limit with round-robin.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              uart_req,
  input  logic              uart_we,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  input  logic              uart_lock,
  output logic              uart_locked,
  output logic              uart_gnt,
  output logic              uart_rvalid,
  output logic [DATA_W-1:0] uart_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises req with we/addr/wdata and holds all of them
  // stable until the cycle its gnt is 1; that cycle the access goes to the RAM.
  // Read data comes back on the owner's rvalid/rdata exactly one cycle later.

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  logic       cpu_gnt_c, uart_gnt_c;
  logic       conflict;
  logic       uart_wins;

  assign conflict = cpu_req & uart_req;

`ifdef DMEM_ARB_RR_EN
  logic last_uart_q, last_uart_d;

  // Remembers who won the last conflict; reset value lets the CPU go first.
  always_comb begin
    last_uart_d = last_uart_q;
    if (conflict && (state_q != ST_LOCKED)) begin
      last_uart_d = uart_gnt_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_uart_q <= 1'b1;
    end else begin
      last_uart_q <= last_uart_d;
    end
  end

  assign uart_wins = ~last_uart_q;
`else
  logic limit_hit;

  arb_starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (cpu_gnt_c & uart_req),
    .clr      (uart_gnt_c | ~uart_req),
    .limit_hit(limit_hit)
  );

  assign uart_wins = limit_hit;
`endif

  // Grants are held low while reset is asserted so nothing reaches the RAM.
  always_comb begin
    cpu_gnt_c  = 1'b0;
    uart_gnt_c = 1'b0;
    if (reset) begin
      if (state_q == ST_LOCKED) begin
        uart_gnt_c = uart_req;
      end else if (conflict) begin
        uart_gnt_c = uart_wins;
        cpu_gnt_c  = ~uart_wins;
      end else begin
        cpu_gnt_c  = cpu_req;
        uart_gnt_c = uart_req;
      end
    end
  end

  // LOCK_PEND waits for a cycle with no CPU access issued; a CPU read issued
  // earlier returns on the owner tag regardless of state, so it needs no wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: begin
        if (uart_lock) begin
          state_d = ST_LOCK_PEND;
        end
      end
      ST_LOCK_PEND: begin
        if (!uart_lock) begin
          state_d = ST_NORMAL;
        end else if (!cpu_req) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (!uart_lock) begin
          state_d = ST_NORMAL;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_gnt_c && !cpu_we) begin
      owner_d = OWN_CPU;
    end else if (uart_gnt_c && !uart_we) begin
      owner_d = OWN_UART;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_NORMAL;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_gnt_c) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (uart_gnt_c) begin
      ram_we    = uart_we;
      ram_addr  = uart_addr;
      ram_wdata = uart_wdata;
    end
  end

  assign ram_en      = cpu_gnt_c | uart_gnt_c;
  assign cpu_gnt     = cpu_gnt_c;
  assign uart_gnt    = uart_gnt_c;
  assign cpu_stall   = cpu_req & ~cpu_gnt_c;

  assign cpu_rvalid  = (owner_q == OWN_CPU);
  assign uart_rvalid = (owner_q == OWN_UART);
  assign cpu_rdata   = cpu_rvalid  ? ram_rdata : '0;
  assign uart_rdata  = uart_rvalid ? ram_rdata : '0;

  assign uart_locked = (state_q == ST_LOCKED);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed + randomized bench for dmem_port_arbiter against a rule-level model.
// Honours DMEM_ARB_RR_EN when compiled alongside a round-robin build.
module tb_dmem_port_arbiter;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int NADDR      = 17;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              cpu_req = 0, cpu_we = 0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              uart_req = 0, uart_we = 0, uart_lock = 0;
  logic [ADDR_W-1:0] uart_addr = '0;
  logic [DATA_W-1:0] uart_wdata = '0;
  logic              cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              uart_locked, uart_gnt, uart_rvalid;
  logic [DATA_W-1:0] uart_rdata;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [1:0]        dbg_state;

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_lock(uart_lock), .uart_locked(uart_locked), .uart_gnt(uart_gnt),
    .uart_rvalid(uart_rvalid), .uart_rdata(uart_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // Synchronous read-first RAM seen by the DUT.
  logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  int                m_starve;
  bit                m_pend, m_excl, m_uart_turn;
  int                m_ret;          // 0 none, 1 cpu, 2 uart
  logic [DATA_W-1:0] m_ret_data;
  bit                e_cg, e_ug;

  // Observed values from the latest checked cycle.
  logic              o_cg, o_ug, o_stall, o_cpu_rvalid, o_uart_rvalid, o_locked;
  logic [DATA_W-1:0] o_cpu_rdata, o_uart_rdata;

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_starve    = 0;
    m_pend      = 0;
    m_excl      = 0;
    m_uart_turn = 0;
    m_ret       = 0;
    m_ret_data  = '0;
  endfunction

  function automatic void predict();
    if (m_excl) begin
      e_cg = 1'b0;
      e_ug = uart_req;
    end else if (cpu_req && uart_req) begin
`ifdef DMEM_ARB_RR_EN
      e_ug = m_uart_turn;
`else
      e_ug = (m_starve >= STARVE_MAX);
`endif
      e_cg = !e_ug;
    end else begin
      e_cg = cpu_req;
      e_ug = uart_req;
    end
  endfunction

  function automatic void model_update();
    m_ret = 0;
    if (e_cg && !cpu_we) begin
      m_ret = 1; m_ret_data = ref_mem[cpu_addr];
    end else if (e_ug && !uart_we) begin
      m_ret = 2; m_ret_data = ref_mem[uart_addr];
    end
    if (e_cg && cpu_we)  ref_mem[cpu_addr]  = cpu_wdata;
    if (e_ug && uart_we) ref_mem[uart_addr] = uart_wdata;
    if (e_ug || !uart_req)         m_starve = 0;
    else if (e_cg && m_starve < STARVE_MAX) m_starve = m_starve + 1;
    if (!m_excl && cpu_req && uart_req) m_uart_turn = !e_ug;
    if (m_excl) begin
      if (!uart_lock) m_excl = 0;
    end else if (m_pend) begin
      if (!uart_lock)    m_pend = 0;
      else if (!cpu_req) begin m_pend = 0; m_excl = 1; end
    end else if (uart_lock) begin
      m_pend = 1;
    end
  endfunction

  // ---------------- driver: one checked clock cycle ----------------
  task automatic cycle();
    @(negedge clk);
    predict();
    o_cg = cpu_gnt; o_ug = uart_gnt; o_stall = cpu_stall;
    o_cpu_rvalid = cpu_rvalid; o_uart_rvalid = uart_rvalid; o_locked = uart_locked;
    o_cpu_rdata = cpu_rdata; o_uart_rdata = uart_rdata;
    check("cpu_gnt",   cpu_gnt,   e_cg);
    check("uart_gnt",  uart_gnt,  e_ug);
    check("cpu_stall", cpu_stall, cpu_req & !e_cg);
    check("ram_en",    ram_en,    e_cg | e_ug);
    if (e_cg) begin
      check("ram_we_cpu",    ram_we,    cpu_we);
      check("ram_addr_cpu",  ram_addr,  cpu_addr);
      check("ram_wdata_cpu", ram_wdata, cpu_wdata);
    end else if (e_ug) begin
      check("ram_we_uart",    ram_we,    uart_we);
      check("ram_addr_uart",  ram_addr,  uart_addr);
      check("ram_wdata_uart", ram_wdata, uart_wdata);
    end
    check("cpu_rvalid",  cpu_rvalid,  m_ret == 1);
    check("uart_rvalid", uart_rvalid, m_ret == 2);
    check("cpu_rdata",   cpu_rdata,   (m_ret == 1) ? m_ret_data : '0);
    check("uart_rdata",  uart_rdata,  (m_ret == 2) ? m_ret_data : '0);
    check("uart_locked", uart_locked, m_excl);
    check("dbg_state",   dbg_state,   m_excl ? 2'd2 : (m_pend ? 2'd1 : 2'd0));
    if (uart_rvalid && exp_q.size() > 0) check("sb_uart_rdata", uart_rdata, exp_q.pop_front());
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; uart_req = 0; cpu_we = 0; uart_we = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_gnt"},     cpu_gnt,     1'b0);
    check({tag, "_uart_gnt"},    uart_gnt,    1'b0);
    check({tag, "_cpu_stall"},   cpu_stall,   1'b0);
    check({tag, "_cpu_rvalid"},  cpu_rvalid,  1'b0);
    check({tag, "_uart_rvalid"}, uart_rvalid, 1'b0);
    check({tag, "_cpu_rdata"},   cpu_rdata,   '0);
    check({tag, "_uart_rdata"},  uart_rdata,  '0);
    check({tag, "_ram_en"},      ram_en,      1'b0);
    check({tag, "_ram_we"},      ram_we,      1'b0);
    check({tag, "_ram_addr"},    ram_addr,    '0);
    check({tag, "_ram_wdata"},   ram_wdata,   '0);
    check({tag, "_uart_locked"}, uart_locked, 1'b0);
    check({tag, "_dbg_state"},   dbg_state,   2'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [9:0] gvec, svec;
    logic [9:0] exp_gvec;
    int         rv_cnt, cg_seen;

    // Reset with requests present: nothing may reach the RAM.
    uart_req = 1; uart_we = 1; uart_addr = 10'h155; uart_wdata = 32'hA5A5_5A5A;
    #12;
    @(negedge clk);
    check_all_zero("reset");
    idle_inputs();
    #2 reset = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // Preload low addresses through the UART, then 0x010 through the CPU.
    for (int a = 0; a < 16; a++) begin
      uart_req = 1; uart_we = 1; uart_addr = ADDR_W'(a); uart_wdata = $urandom;
      cycle();
    end
    uart_req = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h010; cpu_wdata = 32'hDEADBEEF;
    cycle();

    // CPU read of 0x010.
    cpu_we = 0;
    cycle();
    check("cpu_read_gnt", o_cg, 1'b1);
    cpu_req = 0;
    cycle();
    check("cpu_read_rvalid", o_cpu_rvalid, 1'b1);
    check("cpu_read_data",   o_cpu_rdata,  32'hDEADBEEF);
    check("cpu_read_no_uart_rvalid", o_uart_rvalid, 1'b0);

    // Both requesters continuous.
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'd3;
    uart_req = 1; uart_we = 0; uart_addr = 10'd5;
    for (int i = 0; i < 10; i++) begin
      cycle();
      gvec[i] = o_ug;
      svec[i] = o_stall;
    end
`ifdef DMEM_ARB_RR_EN
    exp_gvec = 10'b10_1010_1010;
`else
    exp_gvec = 10'b10_0001_0000;
`endif
    check("grant_pattern", gvec, exp_gvec);
    check("stall_pattern", svec, exp_gvec);
    idle_inputs();
    cycle();

    // Lock requested while a CPU read is in flight.
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'd7; uart_lock = 1;
    cycle();
    check("lock_cpu_gnt", o_cg, 1'b1);
    cpu_req = 0;
    cycle();
    check("lock_cpu_rvalid", o_cpu_rvalid, 1'b1);
    check("lock_not_yet",    o_locked,     1'b0);
    cycle();
    check("lock_rises", o_locked, 1'b1);
    cpu_req = 1; cpu_addr = 10'd9;
    cg_seen = 0;
    rv_cnt  = 0;
    for (int i = 0; i < 4; i++) begin
      uart_req = 1; uart_we = 1; uart_addr = ADDR_W'(i); uart_wdata = DATA_W'(i + 1);
      cycle();
      cg_seen += int'(o_cg);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        uart_req = 1; uart_we = 0; uart_addr = ADDR_W'(i);
        exp_q.push_back(DATA_W'(i + 1));
      end else begin
        uart_req = 0;
      end
      cycle();
      cg_seen += int'(o_cg);
      rv_cnt  += int'(o_uart_rvalid);
    end
    check("lock_rvalid_count", rv_cnt, 4);
    check("lock_no_cpu_gnt",   cg_seen, 0);
    check("lock_cpu_stalled",  o_stall, 1'b1);
    check("sb_drained", exp_q.size(), 0);
    uart_lock = 0;
    cycle();
    check("unlock_cycle_stall", o_stall, 1'b1);
    cycle();
    check("unlock_cpu_gnt", o_cg, 1'b1);
    idle_inputs();
    cycle();

    // Reset one cycle after a UART read grant while locked.
    uart_lock = 1;
    cycle();
    cycle();
    uart_req = 1; uart_we = 0; uart_addr = 10'd2;
    cycle();
    check("pre_reset_locked", o_locked, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    uart_lock = 0;
    idle_inputs();
    #2 reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    cycle();
    check("post_reset_no_rvalid", o_uart_rvalid, 1'b0);

    // Randomized traffic: requests held until the model says granted.
    for (int n = 0; n < 400; n++) begin
      if (!(cpu_req && !e_cg)) begin
        cpu_req   = ($urandom_range(0, 99) < 60);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = ADDR_W'($urandom_range(0, NADDR - 1));
        cpu_wdata = $urandom;
      end
      if (!(uart_req && !e_ug)) begin
        uart_req   = ($urandom_range(0, 99) < 60);
        uart_we    = 1'($urandom_range(0, 1));
        uart_addr  = ADDR_W'($urandom_range(0, NADDR - 1));
        uart_wdata = $urandom;
      end
      if ($urandom_range(0, 24) == 0) uart_lock = !uart_lock;
      cycle();
    end
    uart_lock = 0;
    idle_inputs();
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
